// File: rtl/spy_delay_sensor.sv
// Tapped inverting delay-line sensor: launches an edge, samples every tap one clock later,
// decodes how far the edge travelled and reports sum/min/max depth over a batch of samples.
`timescale 1ns/1ps
module spy_delay_sensor #(
  parameter int CHAIN_LEN = 64,
  parameter int SAMPLE_W  = 8,
  parameter int REST_CYC  = 4,
  parameter int DEPTH_W   = $clog2(CHAIN_LEN+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [SAMPLE_W-1:0]         num_samples,
  output logic                        busy,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [DEPTH_W+SAMPLE_W-1:0] result_sum,
  output logic [DEPTH_W-1:0]          result_min,
  output logic [DEPTH_W-1:0]          result_max,
  output logic                        chain_out
);
  localparam int SUM_W  = DEPTH_W + SAMPLE_W;
  localparam int REST_W = (REST_CYC > 1) ? $clog2(REST_CYC) : 1;
  localparam logic [REST_W-1:0] REST_LAST = REST_W'((REST_CYC > 0) ? REST_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_CAPTURE, S_SYNC, S_DECODE, S_ACCUM, S_REST, S_REPORT
  } state_e;

  state_e                state_q, state_d;
  logic                  launch_q, launch_d;
  logic [CHAIN_LEN-1:0]  cap_q, cap_d, sync_q, sync_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [SUM_W-1:0]      acc_sum_q, acc_sum_d, res_sum_q, res_sum_d;
  logic [DEPTH_W-1:0]    acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [DEPTH_W-1:0]    res_min_q, res_min_d, res_max_q, res_max_d;
  logic [SAMPLE_W-1:0]   cnt_q, cnt_d, n_q, n_d;
  logic                  cont_q, cont_d;
  logic [REST_W-1:0]     rest_q, rest_d;
  logic                  busy_q, busy_d, res_valid_q, res_valid_d;

  // Each stage is its own kept net so synthesis cannot collapse the inverter pairs.
  (* keep *) logic [CHAIN_LEN-1:0] tap;
  for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_stage
    (* keep *) logic o;
    if (i == 0) begin : g_head
      assign o = ~launch_q;
    end else begin : g_body
      assign o = ~g_stage[i-1].o;
    end
    assign tap[i] = o;
  end
  assign chain_out = tap[CHAIN_LEN-1];

  // Settled chain pattern for the current launch level; depth is the matching prefix length.
  logic [CHAIN_LEN-1:0] exp_vec;
  logic [DEPTH_W-1:0]   decode_depth;
  logic                 run;
  always_comb begin
    exp_vec      = '0;
    decode_depth = '0;
    run          = 1'b1;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      exp_vec[i] = launch_q ^ ~i[0];
      if (run && (sync_q[i] == exp_vec[i])) decode_depth = decode_depth + 1'b1;
      else run = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    launch_d    = launch_q;
    cap_d       = cap_q;
    sync_d      = sync_q;
    depth_d     = depth_q;
    acc_sum_d   = acc_sum_q;
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    res_sum_d   = res_sum_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    cont_d      = cont_q;
    rest_d      = rest_q;
    case (state_q)
      S_IDLE: if (start) begin
        cont_d    = continuous;
        n_d       = (num_samples == '0) ? SAMPLE_W'(1) : num_samples;
        acc_sum_d = '0;
        acc_min_d = '1;
        acc_max_d = '0;
        cnt_d     = '0;
        state_d   = S_LAUNCH;
      end
      S_LAUNCH: begin
        launch_d = ~launch_q;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap_d   = tap;
        state_d = S_SYNC;
      end
      S_SYNC: begin
        sync_d  = cap_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        depth_d = decode_depth;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_sum_d = acc_sum_q + SUM_W'(depth_q);
        acc_min_d = (depth_q < acc_min_q) ? depth_q : acc_min_q;
        acc_max_d = (depth_q > acc_max_q) ? depth_q : acc_max_q;
        cnt_d     = cnt_q + 1'b1;
        rest_d    = '0;
        state_d   = S_REST;
      end
      S_REST: begin
        if (rest_q == REST_LAST) begin
          if (cnt_q == n_q) begin
            res_sum_d   = acc_sum_q;
            res_min_d   = acc_min_q;
            res_max_d   = acc_max_q;
            res_valid_d = 1'b1;
            state_d     = S_REPORT;
          end else begin
            state_d = S_LAUNCH;
          end
        end else begin
          rest_d = rest_q + 1'b1;
        end
      end
      S_REPORT: if (result_ready) begin
        res_valid_d = 1'b0;
        if (cont_q) begin
          acc_sum_d = '0;
          acc_min_d = '1;
          acc_max_d = '0;
          cnt_d     = '0;
          state_d   = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      launch_q    <= 1'b0;
      cap_q       <= '0;
      sync_q      <= '0;
      depth_q     <= '0;
      acc_sum_q   <= '0;
      acc_min_q   <= '1;
      acc_max_q   <= '0;
      res_sum_q   <= '0;
      res_min_q   <= '1;
      res_max_q   <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      n_q         <= '0;
      cont_q      <= 1'b0;
      rest_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      cap_q       <= cap_d;
      sync_q      <= sync_d;
      depth_q     <= depth_d;
      acc_sum_q   <= acc_sum_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      res_sum_q   <= res_sum_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      cont_q      <= cont_d;
      rest_q      <= rest_d;
      busy_q      <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = res_valid_q;
  assign result_sum   = res_sum_q;
  assign result_min   = res_min_q;
  assign result_max   = res_max_q;
endmodule

// File: doc/spy_delay_sensor.md
Name: spy_delay_sensor

Overview:
- Parametrised successor to the fixed 100-stage inverting spy path.
- Holds a CHAIN_LEN-stage inverting delay line with every stage output tapped.
- Launches a transition into the chain, samples all taps one clock period later, and decodes how many stages the edge crossed.
- Accumulates sum, min and max depth over a programmable number of samples, then reports them through a valid/ready handshake to the measurement/readout logic.

Parameters:
- CHAIN_LEN, 64: number of inverting delay stages; each stage is a keep-attributed primitive and every tap is observable.
- SAMPLE_W, 8: width of num_samples; sets the maximum samples per measurement.
- REST_CYC, 4: idle cycles after each capture so the chain fully settles before the next launch.
- DEPTH_W, $clog2(CHAIN_LEN+1): width of a single depth value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a measurement; sampled only in IDLE.
- continuous  in  1  sampled with start; 1 = automatically restart after each report.
- num_samples  in  SAMPLE_W  samples per measurement; latched at start; 0 is treated as 1.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  report available.
- result_ready  in  1  consumer accepts the report.
- result_sum  out  DEPTH_W+SAMPLE_W  sum of depths.
- result_min  out  DEPTH_W  minimum depth.
- result_max  out  DEPTH_W  maximum depth.
- chain_out  out  1  last stage output, for external probing.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. On rst, at the next edge:
  - state = IDLE; launch_q = 0; capture and sync registers = 0;
  - busy = 0; result_valid = 0; result_sum = 0; result_min = all ones; result_max = 0;
  - sample counter = 0; latched continuous and num_samples = 0.
- Reset mid-measurement aborts immediately and discards partial results.
- Chain structure: stage0 input is launch_q; tap[i] = NOT(tap[i-1]); stage0 = NOT(launch_q).
- Expected settled value: exp[i] = launch_q XOR ~i[0].
- FSM states, one clock per state unless noted:
  - IDLE: on start, latch continuous and max(num_samples,1); clear accumulators (sum = 0, min = all ones, max = 0); go to LAUNCH.
  - LAUNCH: launch_q toggles at this edge.
  - CAPTURE: cap_q <= tap vector. This gives exactly one clock period of propagation.
  - SYNC: sync_q <= cap_q. This is the metastability guard; decode uses only sync_q.
  - DECODE: depth_q <= count of consecutive i starting at 0 with sync_q[i] == exp[i]. Range 0..CHAIN_LEN; saturates at CHAIN_LEN when all taps match; a mismatch at tap 0 gives 0.
  - ACCUM: sum += depth_q; min = min(min, depth_q); max = max(max, depth_q); increment the sample counter.
  - REST: hold for REST_CYC cycles. Then go to REPORT if count == latched num_samples, else go to LAUNCH.
  - REPORT: result_valid = 1 with outputs registered and stable. On result_valid && result_ready: clear result_valid; go to LAUNCH with accumulators and counter cleared if latched continuous = 1, else go to IDLE.
- Per-sample cost: 5 + REST_CYC cycles.
- Handshake and control:
  - While result_valid && !result_ready: no new launch and outputs frozen.
  - start while busy is ignored; continuous may only be cleared by rst or by finishing a single-shot measurement.
- Width rules:
  - sum width is DEPTH_W+SAMPLE_W, so sum cannot overflow.
  - min and max compare unsigned values.
- Launch polarity alternates each sample. The decode is polarity-independent through exp[i].

Test Plan:
- Bench model: per-stage delay 200 ps, clk 10 ns, zero clock-to-q; num_samples=4, continuous=0, pulse start. Expect depth 50 per sample; one report with result_sum=200, result_min=50, result_max=50; busy falls on handshake; 4*(5+4) cycles from start to result_valid.
- Stage delay 100 ps, CHAIN_LEN=64: chain fully traversed, so expect depth saturated at 64; num_samples=3 gives sum=192, min=max=64.
- Alternating stage delay 200/250 ps between samples (bench-controlled), num_samples=2. Expect min=40, max=50, sum=90; both launch polarities must decode correctly.
- Hold result_ready=0 for 20 cycles after result_valid. Expect outputs stable, launch_q unchanged, no new capture. Raise ready: valid drops next edge; with continuous=1 a new LAUNCH follows immediately and the next report arrives with fresh accumulators.
- Assert rst during SYNC of sample 2. Expect at the next edge all outputs at reset values, busy=0, launch_q=0; a later start gives a correct full measurement.
- num_samples=0 with start: expect exactly one sample and sum equal to that single depth. start pulsed while busy has no effect.
